// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - L1.5 return-type codes and the fixed request type/size
//   - fetch FSM state encoding
//   - prefetch queue entry layout
//   - byte-swap helper (big-endian L1.5 words -> little-endian instructions)
package ifetch_pkg;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] IFILL_RET = 4'b0001;
  localparam logic [3:0] INT_RET   = 4'b0111;

  localparam logic [4:0] IFETCH_RQTYPE = 5'b10000;
  localparam logic [2:0] IFETCH_SIZE   = 3'b000;

  // Marker instruction queued instead of a fetch from a misaligned target.
  localparam logic [31:0] MISALIGN_INSTR = 32'h0000_0033;

  typedef enum logic [1:0] {
    S_SLEEP    = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RESP     = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
  } entry_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch queue: up to four entries pushed per cycle, one popped.
// Ports:
//   clk, nrst           clock, asynchronous active-low reset
//   i_flush             empties the queue; overrides push and pop
//   i_push_n            number of entries to write this cycle (0..4)
//   i_push_e            entries, element 0 written first
//   i_pop               remove head entry (caller guarantees non-empty)
//   o_head_e            head entry
//   o_head_valid        queue non-empty
//   o_count             occupancy
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int QDEPTH = 8,
  localparam int AW = $clog2(QDEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_flush,
  input  logic [2:0]         i_push_n,
  input  entry_t [3:0]       i_push_e,
  input  logic               i_pop,
  output entry_t             o_head_e,
  output logic               o_head_valid,
  output logic [CW-1:0]      o_count
);

  entry_t          r_mem [QDEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) r_head <= r_head + AW'(1);
      // Pointers are AW bits wide, so the additions wrap modulo QDEPTH.
      r_tail  <= r_tail + AW'(i_push_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop);
    end
  end

  // Storage needs no reset: nothing is read out while the count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!i_flush && (3'(i) < i_push_n)) r_mem[r_tail + AW'(i)] <= i_push_e[i];
    end
  end

  assign o_head_e     = r_mem[r_head];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end with prefetch queue between the L1.5
// transducer and decode.
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   br_valid/br_target             branch redirect
//   exc_valid/exc_pc               exception redirect, wins over branch
//   instr_valid/instr_ready        decode handshake: an entry moves when both
//                                  are high at a rising edge; instr_valid never
//                                  waits on instr_ready, and the head holds
//                                  steady until taken or flushed
//   instr_data/pc/misaligned       head entry (zero while empty)
//   transducer_l15_*               fetch request (16-byte block)
//   l15_transducer_*               request acks and response
//   transducer_l15_req_ack         response consumed (mirrors response valid)
//   dbg_state                      current fetch FSM state
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          QDEPTH   = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_misaligned,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [63:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(QDEPTH) + 1;

  state_e        r_state;
  state_e        w_next_state;
  logic [31:0]   r_fetch_pc;
  logic          r_drop;
  logic          r_halt;
  logic          r_mis_pend;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_tgt_misaligned;
  logic          w_req_hs;
  logic          w_outstanding;
  logic          w_complete;
  logic          w_push_resp;
  logic          w_space_ok;
  logic          w_pop;
  logic [2:0]    w_push_n;
  entry_t [3:0]  w_push_e;
  entry_t        w_head_e;
  logic          w_head_valid;
  logic [CW-1:0] w_count;
  logic [31:0]   w_words [4];

  // Redirects are ignored while asleep.
  assign w_redirect       = (exc_valid | br_valid) && (r_state != S_SLEEP);
  assign w_target         = exc_valid ? exc_pc : br_target;
  assign w_tgt_misaligned = (w_target[1:0] != 2'b00);

  // A request is only issued when a full block is guaranteed to fit.
  assign w_space_ok = (32'(w_count) + 32'd4 <= 32'(QDEPTH));

  assign transducer_l15_val     = (r_state == S_REQ) && w_space_ok && !r_halt;
  assign transducer_l15_rqtype  = IFETCH_RQTYPE;
  assign transducer_l15_size    = IFETCH_SIZE;
  assign transducer_l15_address = {r_fetch_pc[31:4], 4'b0000};
  assign transducer_l15_data    = 64'd0;
  assign transducer_l15_req_ack = l15_transducer_val;

  assign w_req_hs      = transducer_l15_val && l15_transducer_header_ack;
  assign w_outstanding = (r_state == S_WAIT_ACK) || (r_state == S_RESP) || w_req_hs;
  assign w_complete    = (r_state == S_RESP) && l15_transducer_val &&
                         ((l15_transducer_returntype == IFILL_RET) ||
                          (l15_transducer_returntype == LOAD_RET));
  assign w_push_resp   = w_complete && !r_drop && !w_redirect;

  assign w_words[0] = l15_transducer_data_0[63:32];
  assign w_words[1] = l15_transducer_data_0[31:0];
  assign w_words[2] = l15_transducer_data_1[63:32];
  assign w_words[3] = l15_transducer_data_1[31:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_SLEEP;
    else       r_state <= w_next_state;
  end

  // A redirect never changes the state: an outstanding request is still
  // drained through WAIT_ACK/RESP, with r_drop discarding its data.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SLEEP: begin
        if (l15_transducer_val && (l15_transducer_returntype == INT_RET))
          w_next_state = S_REQ;
      end
      S_REQ: begin
        if (w_req_hs) w_next_state = l15_transducer_ack ? S_RESP : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (l15_transducer_ack) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (w_complete) w_next_state = S_REQ;
      end
      default: w_next_state = S_SLEEP;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
      r_halt     <= 1'b0;
      r_mis_pend <= 1'b0;
    end else begin
      r_mis_pend <= w_redirect && w_tgt_misaligned;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_halt     <= w_tgt_misaligned;
        // A response arriving in the redirect cycle is consumed right now,
        // so only a still-pending one needs dropping later.
        r_drop     <= w_outstanding && !w_complete;
      end else begin
        if (w_complete) r_drop <= 1'b0;
        if (w_push_resp) r_fetch_pc <= {r_fetch_pc[31:4] + 28'd1, 4'b0000};
      end
    end
  end

  // The misaligned marker is queued the cycle after the flush so that the
  // flush is visible as one empty cycle; r_fetch_pc already holds the target.
  always_comb begin
    w_push_n = 3'd0;
    w_push_e = '0;
    if (r_mis_pend) begin
      w_push_n             = 3'd1;
      w_push_e[0].instr      = MISALIGN_INSTR;
      w_push_e[0].pc         = r_fetch_pc;
      w_push_e[0].misaligned = 1'b1;
    end else if (w_push_resp) begin
      w_push_n = 3'd4 - {1'b0, r_fetch_pc[3:2]};
      for (int k = 0; k < 4; k++) begin
        w_push_e[k].instr      = bswap32(w_words[r_fetch_pc[3:2] + 2'(k)]);
        w_push_e[k].pc         = {r_fetch_pc[31:4], r_fetch_pc[3:2] + 2'(k), 2'b00};
        w_push_e[k].misaligned = 1'b0;
      end
    end
  end

  assign w_pop = w_head_valid && instr_ready && !w_redirect;

  ifetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk          (clk),
    .nrst         (nrst),
    .i_flush      (w_redirect),
    .i_push_n     (w_push_n),
    .i_push_e     (w_push_e),
    .i_pop        (w_pop),
    .o_head_e     (w_head_e),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  assign instr_valid      = w_head_valid;
  assign instr_data       = w_head_valid ? w_head_e.instr : 32'd0;
  assign instr_pc         = w_head_valid ? w_head_e.pc : 32'd0;
  assign instr_misaligned = w_head_valid && w_head_e.misaligned;
  assign dbg_state        = r_state;

endmodule
